// File: rtl/power_pkg.sv
// Shared types and constants for the modular exponentiation engine.
// Latency: none (definitions only). Backpressure: not applicable.
package power_pkg;

    localparam int NBITS_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        LOOP_ISSUE,
        LOOP_WAIT,
        DONE
    } state_t;

    // Start pulse to done pulse of mod_mult: one cycle per 2-bit digit plus the load cycle.
    function automatic int mm_latency(input int nbits);
        return nbits / 2 + 1;
    endfunction

endpackage

// File: rtl/power_mod_mult.sv
// Radix-4 interleaved modular multiply p = x*y mod n (requires y < n), one digit per cycle.
// Latency: mm_latency(NBITS) cycles start->done pulse. Backpressure: none, result held until next start.
module mod_mult
    import power_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] y,
    input  logic [NBITS-1:0] n,
    output logic [NBITS-1:0] p,
    output logic             done
);

    localparam int W      = NBITS + 3;
    localparam int DIGITS = mm_latency(NBITS) - 1;
    localparam int CW     = $clog2(DIGITS + 1);

    logic [NBITS-1:0] xs, ys, ns;
    logic [W-1:0]     acc, yx, nx, dy, t, res;
    logic [CW-1:0]    cnt;
    logic             busy;

    // acc < n always holds, so 4*acc + 3*y < 7n and at most six n's need removing.
    always_comb begin
        yx = {3'b000, ys};
        nx = {3'b000, ns};
        case (xs[NBITS-1 -: 2])
            2'd0:    dy = '0;
            2'd1:    dy = yx;
            2'd2:    dy = yx << 1;
            default: dy = (yx << 1) + yx;
        endcase
        t   = (acc << 2) + dy;
        res = t;
        for (int k = 1; k <= 6; k++) begin
            if (t >= nx * W'(k)) begin
                res = t - nx * W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xs   <= '0;
            ys   <= '0;
            ns   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                xs   <= x;
                ys   <= y;
                ns   <= n;
                acc  <= '0;
                cnt  <= CW'(DIGITS);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= res;
                xs  <= xs << 2;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = acc[NBITS-1:0];

endmodule

// File: rtl/power.sv
// Modular exponentiation a0 = a1^a2 mod a3 by right-to-left square-and-multiply, start on rising edge.
// Latency: ~(bits(a2)+1) * (mm_latency+1) cycles. Backpressure: start edges ignored while busy.
module power
    import power_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] a1,
    input  logic [NBITS-1:0] a2,
    input  logic [NBITS-1:0] a3,
    output logic             done,
    output logic [NBITS-1:0] a0
);

    state_t           state, state_nxt;
    logic             start_d, idle_like, st_edge, deg, step;
    logic             c1_go, c2_go, c1_done, c2_done;
    logic [NBITS-1:0] n_q, e_q, r_q, s_q;
    logic [NBITS-1:0] c1_x, c1_y, c1_n, c1_p, c2_p;

    // c1 reduces the base straight from the ports in the latch cycle (a1 as multiplier, 1 as multiplicand).
    mod_mult #(.NBITS(NBITS)) c1 (
        .clk(clk), .rst(rst), .start(c1_go),
        .x(c1_x), .y(c1_y), .n(c1_n), .p(c1_p), .done(c1_done)
    );

    mod_mult #(.NBITS(NBITS)) c2 (
        .clk(clk), .rst(rst), .start(c2_go),
        .x(s_q), .y(s_q), .n(n_q), .p(c2_p), .done(c2_done)
    );

    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        st_edge   = start && !start_d && idle_like;
        deg       = st_edge && (a3 < NBITS'(2));
        step      = c2_done && (c1_done || !e_q[0]);
        c1_x      = idle_like ? a1 : r_q;
        c1_y      = idle_like ? NBITS'(1) : s_q;
        c1_n      = idle_like ? a3 : n_q;
        state_nxt = state;
        c1_go     = 1'b0;
        c2_go     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (st_edge) begin
                    state_nxt = deg ? DONE : PRE;
                    c1_go     = !deg;
                end
            end
            PRE: begin
                if (c1_done) state_nxt = LOOP_ISSUE;
            end
            LOOP_ISSUE: begin
                if (e_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    c1_go     = e_q[0];
                    c2_go     = 1'b1;
                    state_nxt = LOOP_WAIT;
                end
            end
            LOOP_WAIT: begin
                if (step) state_nxt = LOOP_ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_d <= 1'b1;
            done    <= 1'b0;
            a0      <= '0;
            n_q     <= '0;
            e_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
        end else begin
            state   <= state_nxt;
            start_d <= start;
            if (st_edge) begin
                n_q  <= a3;
                e_q  <= a2;
                done <= deg;
                if (deg) a0 <= '0;
            end
            if (state == PRE && c1_done) begin
                s_q <= c1_p;
                r_q <= NBITS'(1);
            end
            if (state == LOOP_ISSUE && e_q == '0) begin
                a0   <= r_q;
                done <= 1'b1;
            end
            if (state == LOOP_WAIT && step) begin
                s_q <= c2_p;
                if (e_q[0]) r_q <= c1_p;
                e_q <= e_q >> 1;
            end
        end
    end

endmodule

// File: tb/tb_power.sv
// Bench for power: directed literals plus random operands against a pow(b,e,m) model.
module tb_power;

    localparam int N = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a1 = '0, a2 = '0, a3 = '0;
    logic [N-1:0] a0;
    logic         done;

    power #(.NBITS(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a1(a1), .a2(a2), .a3(a3), .done(done), .a0(a0)
    );

    always #5 clk = ~clk;

    // Written by the stimulus process only.
    int           phase = 0;
    int           lim = 0;
    bit           exp_deg = 1'b0;
    logic [N-1:0] exp_a0 = '0;
    string        tag = "reset";
    // Written by the compare process only.
    int           n_chk = 0, n_fail = 0, busy_cyc = 0;
    bit           got = 1'b0, tmo = 1'b0;

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Left-to-right exponentiation with native wide arithmetic.
    function automatic logic [N-1:0] modexp(input logic [N-1:0] b, input logic [N-1:0] e,
                                            input logic [N-1:0] m);
        logic [2*N-1:0] r, bb, mm;
        if (m < 2) return '0;
        mm = {{N{1'b0}}, m};
        bb = {{N{1'b0}}, b} % mm;
        r  = 1;
        for (int i = N - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * bb) % mm;
        end
        return r[N-1:0];
    endfunction

    task automatic chk(input bit ok, input string what, input bit want_done, input logic [N-1:0] want_a0);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s/%s: got done=%0b a0=%h after %0d cycles; required done=%0b a0=%h within %0d",
                     tag, what, done, a0, busy_cyc, want_done, want_a0, lim);
        end
    endtask

    // phase 1: a run is active; phase 3: reset values expected.
    always @(negedge clk) begin
        if (phase == 1) begin
            if (!got) begin
                if (busy_cyc == 0 && !exp_deg) begin
                    chk(done === 1'b0, "done_clear", 1'b0, exp_a0);
                end else if (done === 1'b1) begin
                    chk(a0 === exp_a0 && busy_cyc <= lim, "result", 1'b1, exp_a0);
                    got = 1'b1;
                end else if (busy_cyc >= lim) begin
                    chk(1'b0, "timeout", 1'b1, exp_a0);
                    tmo = 1'b1;
                end
                busy_cyc++;
            end else begin
                chk(done === 1'b1 && a0 === exp_a0, "hold", 1'b1, exp_a0);
            end
        end else begin
            busy_cyc = 0;
            got      = 1'b0;
            tmo      = 1'b0;
            if (phase == 3) chk(done === 1'b0 && a0 === '0, "reset", 1'b0, '0);
        end
    end

    task automatic do_reset();
        phase = 0;
        rst   = 1'b1;
        @(posedge clk); #1;
        phase = 3;
        @(posedge clk); #1;
        rst   = 1'b0;
        phase = 0;
    endtask

    task automatic kick(input logic [N-1:0] x, input logic [N-1:0] e, input logic [N-1:0] m,
                        input logic [N-1:0] want, input string name);
        phase = 0;
        start = 1'b0;
        @(posedge clk); #1;
        a1      = x;
        a2      = e;
        a3      = m;
        exp_a0  = want;
        exp_deg = (m < 2);
        lim     = exp_deg ? 3 : 34000;
        tag     = name;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        phase = 1;
        a1    = rnd();
        a2    = rnd();
        a3    = rnd();
    endtask

    task automatic run(input logic [N-1:0] x, input logic [N-1:0] e, input logic [N-1:0] m,
                       input logic [N-1:0] want, input int hold, input string name);
        kick(x, e, m, want, name);
        while (!got && !tmo) @(posedge clk);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] b, e, m;
        do_reset();

        run(N'(3),  N'(5),  N'(7),    N'(5),  100, "t1_3^5%7");
        run(N'(2),  N'(10), N'(1000), N'(24), 3,   "t2_2^10%1000");
        run(N'(10), N'(3),  N'(7),    N'(6),  3,   "t3_base_ge_mod");
        run(rnd(),  N'(0),  N'(13),   N'(1),  3,   "t4_exp0");
        run(rnd(),  rnd(),  N'(1),    N'(0),  3,   "t4_mod1");
        run(rnd(),  rnd(),  N'(0),    N'(0),  3,   "t4_mod0");

        for (int i = 0; i < 6; i++) begin
            b = rnd();
            e = N'($urandom_range(0, 63));
            m = N'($urandom_range(0, 500));
            run(b, e, m, modexp(b, e, m), 3, "rand_small");
        end

        m = rnd();
        m[N-1] = 1'b1;
        m[0] = 1'b1;
        b = rnd();
        e = rnd();
        run(b, e, m, modexp(b, e, m), 3, "full_1");
        b = rnd();
        run(b, e, m, modexp(b, e, m), 3, "full_2");

        b = rnd();
        e = N'($urandom_range(32'h80000, 32'hFFFFF));
        kick(b, e, m, modexp(b, e, m), "mid_loop");
        repeat (600) @(posedge clk);
        #1;
        do_reset();
        b = rnd();
        e = N'($urandom_range(1, 255));
        run(b, e, m, modexp(b, e, m), 3, "after_rst");

        phase = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
